// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end to a 32-bit barrel shifter (LSL/LSR/ASR/ROR).
// Results land in a one-entry register that drains and refills in the same cycle.
module shift_arbiter #(
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_sh,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic [31:0]      req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_sh,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic [31:0]      req1_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_id
);

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;

    logic             ptr_reg;
    logic             slot_free;
    logic             grant_id;
    logic             accept;
    logic [1:0]       op_sh;
    logic [AMT_W-1:0] op_amt;
    logic [31:0]      op_data;
    logic [4:0]       amt_lo;
    logic             amt_big;
    logic [5:0][31:0] stage;
    logic [31:0]      shift_result;

    assign slot_free = !res_valid || res_ready;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = !ptr_reg;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign req0_ready = !reset && slot_free && req0_valid && !grant_id;
    assign req1_ready = !reset && slot_free && req1_valid &&  grant_id;
    assign accept     = req0_ready || req1_ready;

    assign op_sh   = grant_id ? req1_sh   : req0_sh;
    assign op_amt  = grant_id ? req1_amt  : req0_amt;
    assign op_data = grant_id ? req1_data : req0_data;

    generate
        if (AMT_W > 5) begin : g_wide_amt
            assign amt_lo  = op_amt[4:0];
            assign amt_big = |op_amt[AMT_W-1:5];
        end else begin : g_narrow_amt
            assign amt_lo  = 5'(op_amt);
            assign amt_big = 1'b0;
        end
    endgenerate

    // Log-depth barrel: stage gi moves the word by 2**gi when amt bit gi is set.
    assign stage[0] = op_data;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_stage
            localparam int K = 1 << gi;
            logic [31:0] moved;

            always_comb begin
                case (op_sh)
                    SH_LSL:  moved = {stage[gi][31-K:0], {K{1'b0}}};
                    SH_LSR:  moved = {{K{1'b0}}, stage[gi][31:K]};
                    SH_ASR:  moved = {{K{stage[gi][31]}}, stage[gi][31:K]};
                    default: moved = {stage[gi][K-1:0], stage[gi][31:K]};
                endcase
            end

            assign stage[gi+1] = amt_lo[gi] ? moved : stage[gi];
        end
    endgenerate

    // Amounts of 32 or more saturate for the plain shifts; rotate keeps amt mod 32.
    always_comb begin
        shift_result = stage[5];
        if (amt_big) begin
            case (op_sh)
                SH_LSL,
                SH_LSR:  shift_result = 32'h0;
                SH_ASR:  shift_result = {32{op_data[31]}};
                default: shift_result = stage[5];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_data  <= 32'h0;
            res_id    <= 1'b0;
            ptr_reg   <= 1'b1;
        end else begin
            if (accept) begin
                res_valid <= 1'b1;
                res_data  <= shift_result;
                res_id    <= grant_id;
                ptr_reg   <= grant_id;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have parameter AMT_W, default 8, meaning the width of the shift-amount field (the Rs[7:0] convention).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 presents an operation.
REQ-005 The block SHALL have port req0_ready, output, 1 bit: requester 0 operation accepted this cycle.
REQ-006 The block SHALL have port req0_sh, input, 2 bits: shift type (0 LSL, 1 LSR, 2 ASR, 3 ROR).
REQ-007 The block SHALL have port req0_amt, input, AMT_W bits: unsigned shift amount.
REQ-008 The block SHALL have port req0_data, input, 32 bits: operand to shift.
REQ-009 The block SHALL have ports req1_valid, req1_ready, req1_sh, req1_amt and req1_data, identical to the requester-0 ports for requester 1.
REQ-010 The block SHALL have port res_valid, output, 1 bit: the result register holds a valid result.
REQ-011 The block SHALL have port res_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-012 The block SHALL have port res_data, output, 32 bits: the shifted result.
REQ-013 The block SHALL have port res_id, output, 1 bit: the requester that owns res_data.

Function
REQ-014 Handshake: a transfer occurs on any rising edge where valid and ready are both 1.
- A requester SHALL hold sh, amt and data stable while valid=1 and ready=0.
- The block SHALL never drop or duplicate a request.
REQ-015 State: a one-entry result register.
- EMPTY (res_valid=0) -> FULL on acceptance of a request.
- FULL -> EMPTY on res_ready=1 with no new acceptance.
- FULL -> FULL when a drain and an acceptance occur in the same cycle.
REQ-016 Slot availability: slot_free = !res_valid || res_ready.
- reqN_ready SHALL be 1 only when slot_free=1 and requester N holds the grant.
- At most one ready SHALL be high in any cycle.
- Ready is combinational from the valid inputs, res_valid, res_ready and the priority pointer.
REQ-017 Arbitration is round-robin with a 1-bit last-grant pointer.
- Only one valid: that requester is granted.
- Both valid: the requester not equal to the pointer is granted.
- The pointer SHALL update to the granted id only on an actual transfer.
REQ-018 Latency: a request accepted at edge N SHALL appear on res_data/res_id with res_valid=1 immediately after edge N.
- Sustained throughput is one result per cycle while res_ready=1.
REQ-019 While res_valid=1 and res_ready=0, res_data and res_id SHALL be held stable.
REQ-020 Arithmetic, with A = amt taken as unsigned:
- LSL, A>=32: result 0.
- LSR, A>=32: result 0.
- ASR, A>=32: all bits equal data[31].
- ROR: rotates by A mod 32; A=0 returns the data unchanged (no RRX).
- A=0 for any type: result equals data.

Reset
REQ-021 While reset=1: res_valid=0, res_data=0, res_id=0, pointer=1 (requester 0 wins the first tie), both ready outputs 0.
REQ-022 Reset asserted mid-operation SHALL discard any held result immediately, without waiting for a clock edge.
REQ-023 The first acceptance is possible on the first rising edge after reset deasserts.

Verification
REQ-024 The bench SHALL cover:
- req0 LSL data=0x00000001 amt=4, res_ready=1 -> next cycle res_valid=1, res_data=0x00000010, res_id=0.
- req1 ASR data=0x80000000 amt=40 -> res_data=0xFFFFFFFF, res_id=1; then LSR data=0xFFFFFFFF amt=32 -> res_data=0x00000000.
- ROR data=0x000000F1 amt=36 -> res_data=0x1000000F; ROR amt=0 data=0x12345678 -> res_data=0x12345678.
- Both valid continuously from reset, res_ready=1 -> grants alternate 0,1,0,1; one result per cycle; no request lost (scoreboard by id).
- Result held, res_ready=0 for 3 cycles with both valid -> both ready=0 and res_data/res_id stable; raise res_ready -> drain plus the next acceptance in the same cycle.
- Reset pulsed while res_valid=1 -> res_valid=0 before the next edge; after release, both valid -> requester 0 granted first.
